ps2_scancode_rx: RTL and testbench

PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

---
 rtl/ps2_scancode_rx.sv | 193 +++++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: samples the keyboard clock/data on a divided tick,
// assembles 11-bit frames, folds E0/F0 prefixes into flags and queues the
// resulting key events in a small FIFO for the consumer.
module ps2_scancode_rx #(
   parameter int CLK_DIV       = 250,
   parameter int TIMEOUT_TICKS = 4000,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       PS2_CLK,
   input  logic       PS2_DATA,
   output logic       EV_VALID,
   input  logic       EV_READY,
   output logic [7:0] EV_CODE,
   output logic       EV_EXT,
   output logic       EV_BREAK,
   output logic       FRAME_ERR,
   output logic       OVERFLOW
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

   logic [DW-1:0] div_cnt;
   logic          tick;
   logic [1:0]    clk_sync, dat_sync;
   logic          clk_s, dat_s, clk_prev, fall;
   logic [3:0]    bit_cnt;
   logic [10:0]   shreg;
   logic [TW-1:0] to_cnt;
   logic          frame_done, frame_ok, byte_ok;
   logic [7:0]    byte_v;
   state_t        state, nxt;
   logic          push, ev_ext, ev_brk;

   logic [9:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;
   logic          empty, full, pop, wr_en;
   logic [9:0]    head;

   assign tick = (div_cnt == DW'(CLK_DIV - 1));

   // sample-tick divider, wraps every CLK_DIV cycles
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)       div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + 1'b1;
   end

   // two-flop synchronisers; idle bus level is high
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
      end else begin
         clk_sync <= {clk_sync[0], PS2_CLK};
         dat_sync <= {dat_sync[0], PS2_DATA};
      end
   end

   assign clk_s = clk_sync[1];
   assign dat_s = dat_sync[1];
   assign fall  = tick & clk_prev & ~clk_s;

   // keyboard clock level as seen on the previous tick
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)       clk_prev <= 1'b1;
      else if (tick) clk_prev <= clk_s;
   end

   // frame assembly with inactivity timeout on partial frames
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         bit_cnt    <= '0;
         shreg      <= '0;
         to_cnt     <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (fall) begin
            shreg  <= {dat_s, shreg[10:1]};
            to_cnt <= '0;
            if (bit_cnt == 4'd10) begin
               bit_cnt    <= '0;
               frame_done <= 1'b1;
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else if (tick && bit_cnt != 4'd0) begin
            if (to_cnt == TW'(TIMEOUT_TICKS - 1)) begin
               bit_cnt <= '0;
               to_cnt  <= '0;
               shreg   <= '0;
            end else begin
               to_cnt <= to_cnt + 1'b1;
            end
         end
      end
   end

   // shreg holds {stop, parity, D7..D0, start} once frame_done is up
   assign byte_v   = shreg[8:1];
   assign frame_ok = ~shreg[0] & shreg[10] & (^shreg[9:1]);
   assign byte_ok  = frame_done & frame_ok;

   // bad-frame pulse, one cycle
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) FRAME_ERR <= 1'b0;
      else     FRAME_ERR <= frame_done & ~frame_ok;
   end

   // prefix decoder state register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= S_IDLE;
      else     state <= nxt;
   end

   // prefix decoder: E0/F0 only change state, any other byte emits an event
   always_comb begin
      nxt    = state;
      push   = 1'b0;
      ev_ext = 1'b0;
      ev_brk = 1'b0;
      if (byte_ok) begin
         case (state)
            S_IDLE: begin
               if (byte_v == 8'hE0)      nxt = S_EXT;
               else if (byte_v == 8'hF0) nxt = S_BRK;
               else                      push = 1'b1;
            end
            S_EXT: begin
               if (byte_v == 8'hE0)      nxt = S_EXT;
               else if (byte_v == 8'hF0) nxt = S_EXT_BRK;
               else begin
                  push = 1'b1; ev_ext = 1'b1; nxt = S_IDLE;
               end
            end
            S_BRK: begin
               if (byte_v != 8'hF0) begin
                  push = 1'b1; ev_brk = 1'b1; nxt = S_IDLE;
               end
            end
            S_EXT_BRK: begin
               if (byte_v != 8'hF0) begin
                  push = 1'b1; ev_ext = 1'b1; ev_brk = 1'b1; nxt = S_IDLE;
               end
            end
            default: nxt = S_IDLE;
         endcase
      end
   end

   assign empty = (count == '0);
   assign full  = (count == (AW+1)'(FIFO_DEPTH));
   assign pop   = ~empty & EV_READY;
   assign wr_en = push & (~full | pop);

   // event storage; contents are don't-care while empty
   always_ff @(posedge CLK) begin
      if (wr_en) mem[wr_ptr] <= {ev_ext, ev_brk, byte_v};
   end

   // FIFO pointers, occupancy and sticky drop flag
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         OVERFLOW <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push & full & ~pop) OVERFLOW <= 1'b1;
      end
   end

   assign head     = mem[rd_ptr];
   assign EV_VALID = ~empty;
   assign EV_CODE  = empty ? 8'h00 : head[7:0];
   assign EV_BREAK = empty ? 1'b0  : head[8];
   assign EV_EXT   = empty ? 1'b0  : head[9];

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: drives PS/2 frames bit by bit and
// checks decoded events, error pulses, timeout recovery and FIFO overflow.
module tb_ps2_scancode_rx;

   localparam int D  = 4;   // CLK_DIV
   localparam int TO = 20;  // TIMEOUT_TICKS
   localparam int FD = 4;   // FIFO_DEPTH
   localparam int H  = 3 * D;

   logic       CLK = 1'b0;
   logic       RST, PS2_CLK, PS2_DATA, EV_READY;
   logic       EV_VALID, EV_EXT, EV_BREAK, FRAME_ERR, OVERFLOW;
   logic [7:0] EV_CODE;

   int total = 0, passed = 0;
   int cyc = 0, last_fall = 0, rise_cyc = -1, ferr_cnt = 0, ferr0;
   logic ev_prev = 1'b0;

   ps2_scancode_rx #(.CLK_DIV(D), .TIMEOUT_TICKS(TO), .FIFO_DEPTH(FD)) dut (
      .CLK(CLK), .RST(RST), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
      .EV_VALID(EV_VALID), .EV_READY(EV_READY), .EV_CODE(EV_CODE),
      .EV_EXT(EV_EXT), .EV_BREAK(EV_BREAK), .FRAME_ERR(FRAME_ERR),
      .OVERFLOW(OVERFLOW)
   );

   always #5 CLK = ~CLK;

   // cycle index since reset release: equals the DUT divider phase origin
   always @(posedge CLK) cyc <= RST ? 0 : cyc + 1;

   // observe EV_VALID rising edge and FRAME_ERR high cycles
   always @(negedge CLK) begin
      if (EV_VALID && !ev_prev) rise_cyc <= cyc;
      ev_prev <= EV_VALID;
      if (FRAME_ERR) ferr_cnt <= ferr_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic bad);
      return {1'b1, (~^b) ^ bad, b, 1'b0};
   endfunction

   // expected EV_VALID cycle: clock low reaches the synchroniser output two
   // cycles after it is driven, the next tick completes, +2 cycles latency
   function automatic int exp_rise(input int m);
      int n = m + 2;
      while (n % D != D - 1) n++;
      return n + 2;
   endfunction

   task automatic send_bits(input logic [10:0] bits, input int nb);
      for (int i = 0; i < nb; i++) begin
         PS2_DATA = bits[i];
         repeat (H) @(posedge CLK);
         #1 PS2_CLK = 1'b0;
         last_fall = cyc;
         repeat (H) @(posedge CLK);
         #1 PS2_CLK = 1'b1;
         repeat (H) @(posedge CLK);
         #1;
      end
      PS2_DATA = 1'b1;
   endtask

   task automatic send(input logic [7:0] b, input logic bad);
      send_bits(frame_bits(b, bad), 11);
   endtask

   // check head event, pop it, confirm FIFO then empty
   task automatic check_pop(input string tag, input logic [7:0] code, input logic ext, input logic brk);
      @(negedge CLK);
      chk({tag, "_valid"}, EV_VALID, 1);
      chk({tag, "_code"}, EV_CODE, code);
      chk({tag, "_ext"}, EV_EXT, ext);
      chk({tag, "_brk"}, EV_BREAK, brk);
      EV_READY = 1'b1;
      @(posedge CLK);
      #1 EV_READY = 1'b0;
      @(negedge CLK);
      chk({tag, "_empty"}, EV_VALID, 0);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; PS2_CLK = 1'b1; PS2_DATA = 1'b1; EV_READY = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_valid", EV_VALID, 0);
      chk("rst_code", EV_CODE, 0);
      chk("rst_ext", EV_EXT, 0);
      chk("rst_brk", EV_BREAK, 0);
      chk("rst_ferr", FRAME_ERR, 0);
      chk("rst_ovf", OVERFLOW, 0);
      @(posedge CLK);
      #1 RST = 1'b0;

      // plain make code, with latency check
      send(8'h1C, 1'b0);
      chk("lat_1c", rise_cyc, exp_rise(last_fall));
      check_pop("mk_1c", 8'h1C, 1'b0, 1'b0);
      chk("mk_ferr", ferr_cnt, 0);

      // F0 1C: prefix alone emits nothing
      send(8'hF0, 1'b0);
      repeat (5) @(posedge CLK);
      #1 chk("f0_noev", EV_VALID, 0);
      send(8'h1C, 1'b0);
      check_pop("brk_1c", 8'h1C, 1'b0, 1'b1);

      // E0 F0 75
      send(8'hE0, 1'b0);
      send(8'hF0, 1'b0);
      chk("e0f0_noev", EV_VALID, 0);
      send(8'h75, 1'b0);
      check_pop("ebrk_75", 8'h75, 1'b1, 1'b1);

      // bad parity then a good frame
      ferr0 = ferr_cnt;
      send(8'h1C, 1'b1);
      repeat (5) @(posedge CLK);
      #1;
      chk("par_ferr1", ferr_cnt - ferr0, 1);
      chk("par_noev", EV_VALID, 0);
      send(8'h1D, 1'b0);
      check_pop("after_err_1d", 8'h1D, 1'b0, 1'b0);

      // partial frame discarded by timeout
      ferr0 = ferr_cnt;
      send_bits(frame_bits(8'hAA, 1'b0), 5);
      repeat ((TO + 10) * D) @(posedge CLK);
      #1;
      chk("to_noev", EV_VALID, 0);
      chk("to_noferr", ferr_cnt - ferr0, 0);
      send(8'h23, 1'b0);
      check_pop("to_23", 8'h23, 1'b0, 1'b0);

      // reset mid-prefix and mid-frame
      send(8'hE0, 1'b0);
      send_bits(frame_bits(8'hF0, 1'b0), 3);
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1 chk("mid_rst_valid", EV_VALID, 0);
      RST = 1'b0;
      send(8'h1C, 1'b0);
      check_pop("post_rst_1c", 8'h1C, 1'b0, 1'b0);

      // overflow: fill FIFO, one more drops
      send(8'h15, 1'b0);
      send(8'h1C, 1'b0);
      send(8'h1D, 1'b0);
      send(8'h1B, 1'b0);
      chk("full_no_ovf", OVERFLOW, 0);
      send(8'h24, 1'b0);
      @(negedge CLK);
      chk("ovf_set", OVERFLOW, 1);
      chk("drain0", EV_CODE, 8'h15);
      EV_READY = 1'b1;
      @(negedge CLK);
      chk("drain1_v", EV_VALID, 1);
      chk("drain1", EV_CODE, 8'h1C);
      @(negedge CLK);
      chk("drain2_v", EV_VALID, 1);
      chk("drain2", EV_CODE, 8'h1D);
      @(negedge CLK);
      chk("drain3_v", EV_VALID, 1);
      chk("drain3", EV_CODE, 8'h1B);
      @(negedge CLK);
      chk("drain_empty", EV_VALID, 0);
      chk("ovf_sticky", OVERFLOW, 1);
      EV_READY = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
